mem_responder: RTL and testbench

//  Memory-side end of the CPU byte-memory interface: owns a 2**addr_width-byte RAM, serves CPU reads/writes,

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_ram.sv | 29 ++
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory responder: host opcodes, reply codes, FSM states.
package mem_responder_pkg;

  localparam logic [7:0] OP_LOAD = 8'h4C;
  localparam logic [7:0] OP_DUMP = 8'h44;
  localparam logic [7:0] OP_RUN  = 8'h52;
  localparam logic [7:0] OP_HALT = 8'h48;

  localparam logic [7:0] ACK_OK  = 8'h2E;
  localparam logic [7:0] ACK_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_TX,
    S_HALTWAIT,
    S_ACK
  } state_e;

  // Index of the final header byte: 'R' carries only an address, 'L'/'D' add a count.
  function automatic logic [1:0] hdr_last(input logic [7:0] op);
    return (op == OP_RUN) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU byte-memory bus plus host command/reply byte streams seen by the memory responder.
interface mem_responder_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_write;
  logic [7:0]        mem_data_in;
  logic [7:0]        mem_data_out;
  logic              mem_ready;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  mem_raddr, mem_waddr, mem_write, mem_data_in, rx_data, rx_valid, tx_ready,
    output mem_data_out, mem_ready, rx_ready, tx_data, tx_valid
  );

  modport master (
    output mem_raddr, mem_waddr, mem_write, mem_data_in, rx_data, rx_valid, tx_ready,
    input  mem_data_out, mem_ready, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_ram.sv
// 1R1W byte RAM with a registered read port; a same-address write returns the old byte.
module mem_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = mem[raddr];
  end

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the CPU byte bus: owns the RAM, serves CPU reads/writes and runs the
// host command FSM that loads/dumps memory and controls CPU reset, halt and start address.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] cpu_start_address
);

  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [1:0]            hcnt_q, hcnt_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_halt_q, cpu_halt_d;
  logic [addr_width-1:0] start_q, start_d;

  logic                  rx_ready, rx_fire, safe, host_we, ram_we;
  logic [addr_width-1:0] raddr_mux, ram_waddr;
  logic [7:0]            ram_wdata, rdata;

  assign safe     = cpu_reset_q | cpu_halted;
  assign rx_ready = ~reset & (state_q inside {S_IDLE, S_HDR, S_LOAD});
  assign rx_fire  = bus.rx_valid & rx_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    hcnt_d      = hcnt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cpu_reset_d = cpu_reset_q;
    cpu_halt_d  = cpu_halt_q;
    start_d     = start_q;
    host_we     = 1'b0;

    case (state_q)
      S_IDLE: if (rx_fire) begin
        op_d   = bus.rx_data;
        hcnt_d = '0;
        case (bus.rx_data)
          OP_LOAD: begin
            cpu_reset_d = 1'b1;
            state_d     = S_HDR;
          end
          OP_DUMP, OP_RUN: state_d = S_HDR;
          OP_HALT: begin
            cpu_halt_d = 1'b1;
            state_d    = S_HALTWAIT;
          end
          default: begin
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_ERR;
            state_d    = S_ACK;
          end
        endcase
      end

      S_HDR: if (rx_fire) begin
        hcnt_d = hcnt_q + 2'd1;
        // Shifting in the two address bytes leaves exactly the low addr_width bits.
        if (hcnt_q < 2'd2) addr_d = (addr_q << 8) | addr_width'(bus.rx_data);
        else               cnt_d  = {cnt_q[7:0], bus.rx_data};
        if (hcnt_q == hdr_last(op_q)) begin
          case (op_q)
            OP_LOAD: begin
              if (cnt_d == '0) begin
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_OK;
                state_d    = S_ACK;
              end else begin
                state_d = S_LOAD;
              end
            end
            OP_DUMP: begin
              if (!safe) begin
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_ERR;
                state_d    = S_ACK;
              end else if (cnt_d == '0) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_DUMP_RD;
              end
            end
            default: begin
              start_d     = addr_d;
              cpu_halt_d  = 1'b0;
              cpu_reset_d = 1'b0;
              tx_valid_d  = 1'b1;
              tx_data_d   = ACK_OK;
              state_d     = S_ACK;
            end
          endcase
        end
      end

      S_LOAD: if (rx_fire) begin
        host_we = 1'b1;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_OK;
          state_d    = S_ACK;
        end
      end

      S_DUMP_RD:   state_d = S_DUMP_WAIT;

      S_DUMP_WAIT: begin
        tx_valid_d = 1'b1;
        tx_data_d  = rdata;
        state_d    = S_DUMP_TX;
      end

      S_DUMP_TX: if (bus.tx_ready) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_q + 1'b1;
        cnt_d      = cnt_q - 16'd1;
        state_d    = (cnt_q == 16'd1) ? S_IDLE : S_DUMP_RD;
      end

      S_HALTWAIT: if (cpu_halted) begin
        tx_valid_d = 1'b1;
        tx_data_d  = ACK_OK;
        state_d    = S_ACK;
      end

      S_ACK: if (bus.tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      hcnt_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      cpu_halt_q  <= 1'b0;
      start_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      hcnt_q      <= hcnt_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_halt_q  <= cpu_halt_d;
      start_q     <= start_d;
    end
  end

  // Host steals the read port only for the single address-issue cycle of each dumped byte.
  assign raddr_mux = (state_q == S_DUMP_RD) ? addr_q : bus.mem_raddr;
  assign ram_we    = host_we | bus.mem_write;
  assign ram_waddr = host_we ? addr_q : bus.mem_waddr;
  assign ram_wdata = host_we ? bus.rx_data : bus.mem_data_in;

  mem_ram #(.AW(addr_width)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (raddr_mux),
    .rdata (rdata)
  );

  assign bus.mem_data_out = rdata;
  assign bus.mem_ready    = (state_q != S_DUMP_RD);
  assign bus.rx_ready     = rx_ready;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.tx_data      = tx_data_q;
  assign cpu_reset         = cpu_reset_q;
  assign cpu_halt          = cpu_halt_q;
  assign cpu_start_address = start_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: command table, directed corner sequences and a randomized
// command mix checked against a byte-array model of the RAM and CPU control state.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_reset, cpu_halt, cpu_halted;
  logic [AW-1:0] cpu_start_address;

  mem_responder_if #(.ADDR_W(AW)) bus();

  mem_responder #(.addr_width(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .cpu_reset         (cpu_reset),
    .cpu_halt          (cpu_halt),
    .cpu_halted        (cpu_halted),
    .cpu_start_address (cpu_start_address)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nr_cnt = 0;
  int rl_cnt = 0;

  always @(negedge clk) begin
    if (!bus.mem_ready) nr_cnt <= nr_cnt + 1;
    if (!cpu_reset)     rl_cnt <= rl_cnt + 1;
  end

  logic [7:0]    ref_mem [DEPTH];
  logic [7:0]    buf_q   [1024];
  logic          m_rst, m_halt;
  logic [AW-1:0] m_start;

  typedef struct {
    logic [7:0]    op;
    logic [15:0]   a;
    logic [15:0]   n;
    logic [7:0]    reply;
    logic          rst;
    logic [AW-1:0] start;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout after %0d cycles", name, TMO);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready) begin
      @(negedge clk);
      n++;
      if (n > TMO) begin timeout("rx_accept"); break; end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] v);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit rnd, output bit ok);
    int n;
    bit seen, rdy;
    logic [7:0] held;
    n = 0; seen = 0; ok = 0; b = '0; held = '0;
    while (n < TMO) begin
      if (bus.tx_valid) begin
        if (seen) chk("tx_stable", bus.tx_data, held);
        held = bus.tx_data;
        seen = 1;
        rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.tx_ready = rdy;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        if (rdy) begin b = held; ok = 1; return; end
      end else begin
        @(negedge clk);
      end
      n++;
    end
    timeout("tx_byte");
  endtask

  task automatic recv_expect(input string name, input logic [7:0] exp, input bit rnd);
    logic [7:0] r;
    bit ok;
    recv_byte(r, rnd, ok);
    if (ok) chk(name, r, exp);
  endtask

  task automatic expect_quiet(input int k);
    int q;
    q = 0;
    repeat (k) begin
      @(negedge clk);
      if (bus.tx_valid) q++;
    end
    chk("tx_quiet", q, 0);
  endtask

  task automatic host_load(input logic [15:0] a, input int n);
    int rl0;
    send_byte(OP_LOAD);
    m_rst = 1'b1;
    rl0 = rl_cnt;
    send16(a);
    send16(16'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(buf_q[i]);
      ref_mem[(int'(a) + i) % DEPTH] = buf_q[i];
    end
    recv_expect("load_ack", ACK_OK, 1'b0);
    chk("load_cpu_reset_held", rl_cnt - rl0, 0);
  endtask

  task automatic host_dump(input logic [15:0] a, input logic [15:0] n, input bit rnd);
    logic [7:0] r;
    bit ok, sf;
    int nr0;
    sf = m_rst || cpu_halted;
    send_byte(OP_DUMP);
    send16(a);
    send16(n);
    nr0 = nr_cnt;
    if (sf) begin
      for (int i = 0; i < int'(n); i++) begin
        recv_byte(r, rnd, ok);
        if (!ok) break;
        chk("dump_data", r, ref_mem[(int'(a) + i) % DEPTH]);
      end
    end else begin
      recv_expect("dump_refused", ACK_ERR, rnd);
    end
    expect_quiet(4);
    chk("dump_mem_ready_cycles", nr_cnt - nr0, sf ? int'(n) : 0);
  endtask

  task automatic host_run(input logic [15:0] a);
    send_byte(OP_RUN);
    send16(a);
    recv_expect("run_ack", ACK_OK, 1'b0);
    m_rst = 1'b0; m_halt = 1'b0; m_start = a[AW-1:0];
    cpu_halted = 1'b0;
    chk("run_cpu_reset", cpu_reset, m_rst);
    chk("run_cpu_halt", cpu_halt, m_halt);
    chk("run_start", cpu_start_address, m_start);
  endtask

  task automatic host_halt(input int delay);
    int q;
    send_byte(OP_HALT);
    m_halt = 1'b1;
    q = 0;
    repeat (delay) begin
      @(negedge clk);
      if (bus.tx_valid) q++;
    end
    chk("halt_no_early_ack", q, 0);
    chk("halt_req", cpu_halt, m_halt);
    cpu_halted = 1'b1;
    recv_expect("halt_ack", ACK_OK, 1'b1);
    chk("halt_held", cpu_halt, m_halt);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus.mem_waddr = a; bus.mem_data_in = d; bus.mem_write = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    bus.mem_raddr = a;
    @(negedge clk);
    chk("cpu_read", bus.mem_data_out, ref_mem[a]);
  endtask

  initial begin
    logic [7:0] r;
    bit ok;
    int nh;

    tbl[0] = '{8'h00,   16'h0000, 16'h0000, ACK_ERR, 1'b1, 9'h000};
    tbl[1] = '{OP_LOAD, 16'h0010, 16'h0000, ACK_OK,  1'b1, 9'h000};
    tbl[2] = '{OP_RUN,  16'h0123, 16'h0000, ACK_OK,  1'b0, 9'h123};
    tbl[3] = '{OP_DUMP, 16'h0005, 16'h0004, ACK_ERR, 1'b0, 9'h123};
    tbl[4] = '{8'h5A,   16'h0000, 16'h0000, ACK_ERR, 1'b0, 9'h123};
    tbl[5] = '{OP_LOAD, 16'h0200, 16'h0000, ACK_OK,  1'b1, 9'h123};
    tbl[6] = '{OP_RUN,  16'hFE00, 16'h0000, ACK_OK,  1'b0, 9'h000};

    reset = 1'b1; cpu_halted = 1'b0;
    bus.mem_raddr = '0; bus.mem_waddr = '0; bus.mem_write = 1'b0; bus.mem_data_in = '0;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    m_rst = 1'b1; m_halt = 1'b0; m_start = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_data_out", bus.mem_data_out, 8'h00);
    chk("rst_mem_ready", bus.mem_ready, 1'b1);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_cpu_halt", cpu_halt, 1'b0);
    chk("rst_start", cpu_start_address, 9'h000);
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Fill the whole RAM so every later dump/read has a known reference.
    for (int i = 0; i < DEPTH; i++) buf_q[i] = 8'($urandom);
    host_load(16'h0000, DEPTH);

    for (int t = 0; t < 7; t++) begin
      int nr0;
      nr0 = nr_cnt;
      nh = (tbl[t].op == OP_LOAD || tbl[t].op == OP_DUMP) ? 4 : (tbl[t].op == OP_RUN) ? 2 : 0;
      send_byte(tbl[t].op);
      if (nh > 0) send16(tbl[t].a);
      if (nh > 2) send16(tbl[t].n);
      recv_byte(r, 1'b0, ok);
      if (ok) chk($sformatf("tbl%0d_reply", t), r, tbl[t].reply);
      expect_quiet(2);
      chk($sformatf("tbl%0d_cpu_reset", t), cpu_reset, tbl[t].rst);
      chk($sformatf("tbl%0d_start", t), cpu_start_address, tbl[t].start);
      chk($sformatf("tbl%0d_mem_ready", t), nr_cnt - nr0, 0);
    end
    m_rst = 1'b0; m_halt = 1'b0; m_start = '0;

    buf_q[0] = 8'hAA; buf_q[1] = 8'hBB; buf_q[2] = 8'hCC;
    host_load(16'h0010, 3);

    host_run(16'h0000);
    cpu_read(9'h010);

    for (int i = 2; i < 6; i++) cpu_write(AW'(i), 8'h00);
    host_halt(20);
    host_dump(16'h0002, 16'h0004, 1'b1);
    host_dump(16'h000E, 16'h0006, 1'b1);

    host_run(16'h0040);
    host_dump(16'h0010, 16'h0003, 1'b0);
    cpu_read(9'h011);

    buf_q[0] = 8'h11; buf_q[1] = 8'h22;
    host_load(16'h01FF, 2);
    host_dump(16'h01FF, 16'h0002, 1'b0);
    host_dump(16'h0100, 16'h0000, 1'b0);

    // Host write and CPU write to the same byte on the same edge: host data must land.
    send_byte(OP_LOAD); send16(16'h0030); send16(16'h0001);
    bus.mem_waddr = 9'h030; bus.mem_data_in = 8'h55; bus.mem_write = 1'b1;
    send_byte(8'h99);
    bus.mem_write = 1'b0;
    ref_mem[9'h030] = 8'h99;
    recv_expect("collide_ack", ACK_OK, 1'b0);
    host_dump(16'h0030, 16'h0001, 1'b0);

    for (int i = 0; i < 600; i++) buf_q[i] = 8'($urandom);
    host_load(16'h01F0, 600);
    host_dump(16'h01F0, 16'h0030, 1'b1);

    host_run(16'h0077);
    send_byte(OP_LOAD); send16(16'h0040); send16(16'h0005);
    send_byte(8'h77); send_byte(8'h88);
    ref_mem[9'h040] = 8'h77; ref_mem[9'h041] = 8'h88;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx_valid", bus.tx_valid, 1'b0);
    chk("midrst_cpu_reset", cpu_reset, 1'b1);
    chk("midrst_start", cpu_start_address, 9'h000);
    reset = 1'b0; cpu_halted = 1'b0;
    m_rst = 1'b1; m_halt = 1'b0; m_start = '0;
    @(negedge clk);
    host_dump(16'h0040, 16'h0003, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          int n;
          n = $urandom_range(0, 12);
          for (int i = 0; i < n; i++) buf_q[i] = 8'($urandom);
          host_load(16'($urandom), n);
        end
        1: host_dump(16'($urandom), 16'($urandom_range(0, 10)), 1'b1);
        2: begin
          if (!cpu_halted) begin
            if (!m_rst) repeat (3) cpu_write(AW'($urandom), 8'($urandom));
            host_halt($urandom_range(1, 6));
          end else begin
            host_run(16'($urandom));
          end
        end
        default: cpu_read(AW'($urandom));
      endcase
      chk("rand_cpu_reset", cpu_reset, m_rst);
      chk("rand_cpu_halt", cpu_halt, m_halt);
      chk("rand_start", cpu_start_address, m_start);
    end

    for (int i = 0; i < 8; i++) cpu_read(AW'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
